// File: rtl/slicel_cfg_pkg.sv
// slicel_cfg_pkg: shared states, error codes and frame-size helpers for the slicel config loader.
package slicel_cfg_pkg;
  typedef enum logic [2:0] {IDLE, COLLECT, COMMIT, DONE, ERROR} state_t;
  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_EARLY_LAST = 2'b01;
  localparam logic [1:0] ERR_NO_LAST    = 2'b10;
  localparam logic [1:0] ERR_ABORT      = 2'b11;
  function automatic int frame_bits(input int s_xx_base, input int num_luts);
    return num_luts * 2 * ((1 << s_xx_base) + 1) + 1;
  endfunction
  function automatic int num_words(input int s_xx_base, input int num_luts, input int word_w);
    return (frame_bits(s_xx_base, num_luts) + word_w - 1) / word_w;
  endfunction
endpackage

// File: rtl/slicel_cfg_shadow.sv
// slicel_cfg_shadow: word-indexed frame shadow (ports: cclk, rst_n, we, idx, data in; frame, frame_nxt out).
module slicel_cfg_shadow
  import slicel_cfg_pkg::*;
#(
  parameter int FRAME_BITS = 137,
  parameter int WORD_W     = 8,
  parameter int IDX_W      = 5
) (
  input  logic                  cclk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [WORD_W-1:0]     data,
  output logic [FRAME_BITS-1:0] frame,
  output logic [FRAME_BITS-1:0] frame_nxt
);
  logic [FRAME_BITS-1:0] wd, wm;
  // bits shifted past the top of the frame fall off, which drops final-word padding
  always_comb begin
    wd        = FRAME_BITS'(data) << (idx * WORD_W);
    wm        = FRAME_BITS'({WORD_W{1'b1}}) << (idx * WORD_W);
    frame_nxt = we ? ((frame & ~wm) | wd) : frame;
  end
  always_ff @(posedge cclk or negedge rst_n)
    if (!rst_n) frame <= '0;
    else        frame <= frame_nxt;
endmodule

// File: rtl/slicel_cfg_loader.sv
// slicel_cfg_loader: collects a config stream into a slice frame and commits it with a one-cycle cen pulse.
// ports: cclk, rst_n, start, abort, cfg_data/cfg_valid/cfg_last in, cfg_ready out;
//        luts_config_out, use_cc_out, cen_out to the slice; busy, done, err, err_code to the controller.
module slicel_cfg_loader
  import slicel_cfg_pkg::*;
#(
  parameter int S_XX_BASE = 4,
  parameter int CFG_SIZE  = 2**S_XX_BASE + 1,
  parameter int NUM_LUTS  = 4,
  parameter int WORD_W    = 8
) (
  input  logic                           cclk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [WORD_W-1:0]              cfg_data,
  input  logic                           cfg_valid,
  input  logic                           cfg_last,
  output logic                           cfg_ready,
  output logic [NUM_LUTS*2*CFG_SIZE-1:0] luts_config_out,
  output logic                           use_cc_out,
  output logic                           cen_out,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [1:0]                     err_code
);
  localparam int FRAME_BITS = frame_bits(S_XX_BASE, NUM_LUTS);
  localparam int NUM_WORDS  = num_words(S_XX_BASE, NUM_LUTS, WORD_W);
  localparam int IDX_W      = $clog2(NUM_WORDS);
  state_t state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic [1:0] code_nxt;
  logic accept, at_end;
  logic [FRAME_BITS-1:0] frame, frame_nxt;
  assign cfg_ready = state == COLLECT;
  assign busy      = state == COLLECT || state == COMMIT;
  assign cen_out   = state == COMMIT;
  assign done      = state == DONE;
  assign err       = state == ERROR;
  slicel_cfg_shadow #(.FRAME_BITS(FRAME_BITS), .WORD_W(WORD_W), .IDX_W(IDX_W)) u_shadow (
    .cclk      (cclk),
    .rst_n     (rst_n),
    .we        (accept),
    .idx       (cnt),
    .data      (cfg_data),
    .frame     (frame),
    .frame_nxt (frame_nxt)
  );
  // abort outranks the handshake, so a word offered alongside abort is dropped
  always_comb begin
    accept    = cfg_valid && state == COLLECT && !abort;
    at_end    = cnt == IDX_W'(NUM_WORDS - 1);
    state_nxt = state;
    code_nxt  = err_code;
    cnt_nxt   = accept ? cnt + 1'b1 : cnt;
    case (state)
      IDLE, DONE, ERROR:
        if (start) begin
          state_nxt = COLLECT;
          code_nxt  = ERR_NONE;
          cnt_nxt   = '0;
        end
      COLLECT:
        if (abort) begin
          state_nxt = ERROR;
          code_nxt  = ERR_ABORT;
        end else if (accept && at_end) begin
          state_nxt = cfg_last ? COMMIT : ERROR;
          code_nxt  = cfg_last ? err_code : ERR_NO_LAST;
        end else if (accept && cfg_last) begin
          state_nxt = ERROR;
          code_nxt  = ERR_EARLY_LAST;
        end
      COMMIT:  state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // the frame is captured with the final word folded in so it is stable while cen is high
  always_ff @(posedge cclk or negedge rst_n)
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      err_code        <= ERR_NONE;
      luts_config_out <= '0;
      use_cc_out      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      err_code <= code_nxt;
      if (state_nxt == COMMIT) begin
        luts_config_out <= frame_nxt[FRAME_BITS-1:1];
        use_cc_out      <= frame_nxt[0];
      end
    end
endmodule

// File: tb/tb_slicel_cfg_loader.sv
// tb_slicel_cfg_loader: randomized self-checking bench for slicel_cfg_loader against a frame-level model.
module tb_slicel_cfg_loader;
  logic cclk = 0, rst_n = 0, start = 0, abort = 0, cfg_valid = 0, cfg_last = 0;
  logic [7:0] cfg_data = 0;
  logic cfg_ready, use_cc_out, cen_out, busy, done, err;
  logic [135:0] luts_config_out;
  logic [1:0] err_code;
  int n_vec = 0, n_bad = 0;
  logic [7:0] w [18];
  logic [135:0] exp_luts = '0;
  logic exp_cc = 0;

  slicel_cfg_loader dut (
    .cclk(cclk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_last(cfg_last), .cfg_ready(cfg_ready),
    .luts_config_out(luts_config_out), .use_cc_out(use_cc_out), .cen_out(cen_out),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 cclk = ~cclk;

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  // stream word k bit b is frame bit 8k+b; anything past bit 136 is padding
  function automatic logic [136:0] model_frame();
    logic [136:0] f = '0;
    for (int k = 0; k < 18; k++)
      for (int b = 0; b < 8; b++)
        if (k * 8 + b < 137) f[k * 8 + b] = w[k][b];
    return f;
  endfunction

  // last_at: word flagged cfg_last (-1 none); abort_at: word offered together with abort (-1 none)
  task automatic load(input int last_at, input int abort_at, input bit stall);
    int cens = 0;
    int outcome = 0;
    logic [136:0] f;
    logic [1:0] want_code;
    start = 1;
    abort = 1'($urandom % 2);
    tick();
    start = 0;
    abort = 0;
    check("start_ready", cfg_ready, 1);
    check("start_busy", busy, 1);
    check("start_flags", {done, err, err_code}, 0);
    for (int k = 0; k < 18; k++) begin
      if (stall && k % 2 == 1)
        repeat (3) begin
          cfg_valid = 0;
          start = 1'($urandom % 2);
          tick();
          cens += int'(cen_out);
          check("stall_ready", cfg_ready, 1);
        end
      start = 0;
      cfg_valid = 1;
      cfg_data = w[k];
      cfg_last = k == last_at;
      abort = k == abort_at;
      tick();
      cens += int'(cen_out);
      cfg_valid = 0;
      cfg_last = 0;
      abort = 0;
      if (k == abort_at) begin outcome = 3; break; end
      if (k == 17) begin outcome = (last_at == 17) ? 0 : 2; break; end
      if (k == last_at) begin outcome = 1; break; end
    end
    f = model_frame();
    if (outcome == 0) begin
      exp_luts = f[136:1];
      exp_cc = f[0];
      check("cen_pulse", cen_out, 1);
      check("cen_count", cens, 1);
      check("commit_luts", luts_config_out, exp_luts);
      check("commit_cc", use_cc_out, exp_cc);
      check("commit_done", done, 0);
      abort = 1'($urandom % 2);
      tick();
      abort = 0;
      check("cen_after", cen_out, 0);
      check("done", {done, err, busy}, 3'b100);
    end else begin
      want_code = outcome == 1 ? 2'b01 : outcome == 2 ? 2'b10 : 2'b11;
      check("err_no_cen", cens, 0);
      check("err_flags", {done, err, busy, cfg_ready}, 4'b0100);
      check("err_code", err_code, want_code);
      check("err_luts", luts_config_out, exp_luts);
      check("err_cc", use_cc_out, exp_cc);
    end
    tick();
    check("idle_cen", cen_out, 0);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_out", {cfg_ready, use_cc_out, cen_out, busy, done, err, err_code}, 0);
    check("rst_luts", luts_config_out, 0);
    @(negedge cclk);
    rst_n = 1;
    tick();
    for (int k = 0; k < 18; k++) w[k] = 8'(k + 1);
    load(5, -1, 0);
    load(17, -1, 0);
    check("nom_cc", use_cc_out, 1);
    check("nom_lsb", luts_config_out[7:0], 0);
    load(17, -1, 1);
    check("stall_cc", use_cc_out, 1);
    load(-1, -1, 0);
    load(17, -1, 0);
    check("recover_err", err, 0);
    load(17, 10, 0);
    for (int k = 0; k < 18; k++) w[k] = 8'hFF;
    load(17, -1, 0);
    check("ff_cc", use_cc_out, 1);
    check("ff_luts", luts_config_out, {136{1'b1}});
    for (int i = 0; i < 24; i++) begin
      int mode = int'($urandom % 4);
      for (int k = 0; k < 18; k++) w[k] = 8'($urandom);
      case (mode)
        0: load(17, -1, 1'($urandom % 2));
        1: load(int'($urandom % 17), -1, 1'($urandom % 2));
        2: load(-1, -1, 1'($urandom % 2));
        default: load(17, int'($urandom % 18), 1'($urandom % 2));
      endcase
    end
    for (int k = 0; k < 18; k++) w[k] = 8'($urandom) | 8'h01;
    start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 18; k++) begin
      cfg_valid = 1;
      cfg_data = w[k];
      cfg_last = k == 17;
      tick();
    end
    cfg_valid = 0;
    cfg_last = 0;
    check("rc_cen", cen_out, 1);
    #3 rst_n = 0;
    #1;
    check("rc_out", {cen_out, done, use_cc_out, busy}, 0);
    check("rc_luts", luts_config_out, 0);
    #1 rst_n = 1;
    tick();
    check("rc_idle", {cfg_ready, busy, done, err, err_code}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
